key_event_queue: RTL and testbench
==================================

Name: key_event_queue

Overview:
- Sits directly downstream of the keyboard decoder. It consumes that stage's 8-bit level output, which holds an ASCII code ('A'-'Z' = 0x41-0x5A, '1'-'4' = 0x31-0x34) while a key is held and 0x00 otherwise.
- Converts each new key press into exactly one event and queues events in a small FIFO.
- Game or display logic pops events at its own pace with a first-word-fall-through read handshake.

Parameters:
- DEPTH, 8, number of FIFO entries; must be a power of two, minimum 2.
- AW, 3, address width; must equal log2(DEPTH).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- clr  in  1  asynchronous, active-high reset.
- en  in  1  event capture enable; when low, no pushes occur.
- key_code  in  8  level ASCII code from the keyboard stage (0x00 = no key).
- rd_en  in  1  pop request for the head entry.
- clr_ovf  in  1  synchronous clear of the overflow flag.
- valid  out  1  FIFO not empty; key_out is meaningful.
- key_out  out  8  head entry ASCII code (FWFT).
- key_is_digit  out  1  head entry is in 0x31-0x34.
- count  out  AW+1  number of occupied entries, 0..DEPTH.
- overflow  out  1  sticky; set when an event is dropped because the FIFO is full.

Behaviour:
- Reset (clr=1, asynchronous):
  - prev_code, write pointer, read pointer and count go to 0.
  - valid=0, key_out=0x00, key_is_digit=0, overflow=0.
  - Reset mid-operation discards all queued events immediately, with no clock required.
- prev_code register: loads key_code on every clock edge regardless of en, so asserting en never produces a spurious event for a key already held.
- Event detect (combinational): evt = en & (key_code != 0) & (key_code != prev_code) & legal(key_code).
  - legal(key_code) = 0x41..0x5A or 0x31..0x34.
  - Illegal nonzero codes are never pushed, but prev_code still tracks them.
- Event cases:
  - Held key or typematic repeat (key_code unchanged): one event only.
  - Sequence A, 0x00, A: two events.
  - Direct change A→B with no intervening 0x00: event for B.
- Push: on the edge where evt=1 and the FIFO is not full, key_code is written at the write pointer; the pointer increments modulo DEPTH.
- Pop: on the edge where rd_en=1 and valid=1, the read pointer increments modulo DEPTH. rd_en while empty is ignored, with no underflow and no state change.
- Latency: key_code reaches a new legal value before edge E → valid=1 and key_out = code after E (1 cycle).
- Outputs: key_out and key_is_digit are driven from the head entry. When empty, key_out=0x00 and key_is_digit=0.
- Full (count=DEPTH) with evt=1 and no pop: event dropped, overflow←1, contents unchanged.
- Full with evt=1 and pop on the same edge: both occur, count stays DEPTH, overflow unchanged.
- Empty with evt=1 and rd_en=1: push occurs, pop ignored (no bypass), count=1.
- count: +1 on push only, −1 on pop only, unchanged on both or neither. Range 0..DEPTH is exact, with full = (count==DEPTH).
- Pointers: wrap from DEPTH−1 to 0. Ordering is strict FIFO.
- overflow: cleared only by clr or clr_ovf=1. If clr_ovf and a new drop occur on the same edge, the set wins (overflow=1).

Decomposition:
- Shared constants header:
  - KEY_NONE=8'h00
  - KEY_A=8'h41, KEY_Z=8'h5A
  - KEY_1=8'h31, KEY_4=8'h34
  - This header is also used by the keyboard decoder and game FSM.
- One sub-module, key_fifo: parameterised DEPTH/AW synchronous FWFT FIFO with push, pop, count, full and empty.
- The top level holds prev_code, the event detect, legality/digit decode and the overflow flag.

Test Plan:
1. Reset, then key_code = 0x41 held for 20 cycles with en=1 → exactly one entry. valid=1 one cycle after the first edge, key_out=0x41, count=1, key_is_digit=0.
2. key_code sequence 0x41, 0x00, 0x41, 0x42, 0x33 (each held 3 cycles), then pop 4 times → key_out 0x41, 0x41, 0x42, 0x33 in that order. key_is_digit=1 only on 0x33. count returns to 0 and valid=0.
3. Push 9 distinct events with DEPTH=8 and no pops → count=8 and overflow=1, with the first 8 retained in order. Pulse clr_ovf → overflow=0. Full plus simultaneous push and pop → count=8, overflow stays 0.
4. Hold key_code=0x45 with en=0, then raise en while still held → no push. Then key_code=0x00, then 0x45 → one push.
5. Inputs key_code=0x35, 0x5B and 0x61 → no pushes. rd_en pulses on empty → count=0, no change.
6. Fill 5 entries, assert clr between clock edges → valid, count and overflow go to 0 immediately. Then new event 0x31 → key_out=0x31, count=1.

Source files
------------

// File: rtl/key_event_queue_pkg.sv
// Shared key-code constants and decode helpers.
// Also used by the keyboard decoder and the game FSM.
package key_event_queue_pkg;

    localparam logic [7:0] KEY_NONE = 8'h00;
    localparam logic [7:0] KEY_A    = 8'h41;
    localparam logic [7:0] KEY_Z    = 8'h5A;
    localparam logic [7:0] KEY_1    = 8'h31;
    localparam logic [7:0] KEY_4    = 8'h34;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= KEY_1) && (c <= KEY_4);
    endfunction

    function automatic logic is_legal(input logic [7:0] c);
        return ((c >= KEY_A) && (c <= KEY_Z)) || is_digit(c);
    endfunction

endpackage

// File: rtl/key_event_queue_key_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module key_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          i_clk,
    input  logic          i_clr,
    input  logic          i_push,
    input  logic [7:0]    i_data,
    input  logic          i_pop,
    output logic [7:0]    o_head,
    output logic [AW:0]   o_count,
    output logic          o_full,
    output logic          o_empty
);

    logic [7:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;

    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = i_pop & ~w_empty;
    assign w_push  = i_push & (~w_full | w_pop);

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointers and count; pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/key_event_queue.sv
// Turns level key codes into one event per new press and queues them.
// Holds previous-code tracking, event detect, head decode and overflow flag.
module key_event_queue
    import key_event_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          en,
    input  logic [7:0]    key_code,
    input  logic          rd_en,
    input  logic          clr_ovf,
    output logic          valid,
    output logic [7:0]    key_out,
    output logic          key_is_digit,
    output logic [AW:0]   count,
    output logic          overflow
);

    logic [7:0] r_prev_code;
    logic       r_overflow;

    logic       w_evt;
    logic       w_drop;
    logic [7:0] w_head;
    logic       w_full;
    logic       w_empty;

    assign w_evt = en && (key_code != KEY_NONE)
                 && (key_code != r_prev_code)
                 && is_legal(key_code);

    assign w_drop = w_evt & w_full & ~(rd_en & ~w_empty);

    key_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .i_clk   (clk),
        .i_clr   (clr),
        .i_push  (w_evt),
        .i_data  (key_code),
        .i_pop   (rd_en),
        .o_head  (w_head),
        .o_count (count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Track the last code unconditionally so enabling never fires on a held key.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_prev_code <= KEY_NONE;
        end else begin
            r_prev_code <= key_code;
        end
    end

    // Sticky overflow; a new drop beats a simultaneous clear request.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    assign valid        = ~w_empty;
    assign key_out      = w_empty ? KEY_NONE : w_head;
    assign key_is_digit = ~w_empty & is_digit(w_head);
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_key_event_queue.sv
// Scoreboard bench for key_event_queue: stimulus queues expected events,
// a negedge monitor checks each popped head against the queue.
module tb_key_event_queue;

    typedef struct packed {
        logic [7:0] key;
        logic       dig;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       en = 1'b0;
    logic [7:0] key_code = 8'h00;
    logic       rd_en = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       valid;
    logic [7:0] key_out;
    logic       key_is_digit;
    logic [3:0] count;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    key_event_queue #(.DEPTH(8), .AW(3)) dut (
        .clk          (clk),
        .clr          (clr),
        .en           (en),
        .key_code     (key_code),
        .rd_en        (rd_en),
        .clr_ovf      (clr_ovf),
        .valid        (valid),
        .key_out      (key_out),
        .key_is_digit (key_is_digit),
        .count        (count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_evt(input logic [7:0] k, input logic d);
        exp_t e;
        e.key = k;
        e.dig = d;
        exp_q.push_back(e);
    endtask

    task automatic pop1();
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
    endtask

    // Monitor: whenever a pop is presented to a valid head, compare it.
    always @(negedge clk) begin
        if (!clr && rd_en && valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got %0h expected none", key_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pop_key", int'(key_out), int'(e.key));
                check("pop_digit", int'(key_is_digit), int'(e.dig));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset values, then a held key gives one event
        #3;
        check("rst_valid", int'(valid), 0);
        check("rst_key", int'(key_out), 0);
        check("rst_count", int'(count), 0);
        check("rst_ovf", int'(overflow), 0);
        @(posedge clk); #1;
        clr = 1'b0;
        en = 1'b1;
        key_code = 8'h41;
        expect_evt(8'h41, 1'b0);
        step(1);
        check("t1_valid", int'(valid), 1);
        check("t1_key", int'(key_out), 8'h41);
        check("t1_count", int'(count), 1);
        check("t1_digit", int'(key_is_digit), 0);
        step(19);
        check("t1_held_count", int'(count), 1);
        pop1();
        key_code = 8'h00;
        step(1);

        // 2: release/re-press, direct change, digit
        key_code = 8'h41; expect_evt(8'h41, 1'b0); step(3);
        key_code = 8'h00; step(3);
        key_code = 8'h41; expect_evt(8'h41, 1'b0); step(3);
        key_code = 8'h42; expect_evt(8'h42, 1'b0); step(3);
        key_code = 8'h33; expect_evt(8'h33, 1'b1); step(3);
        check("t2_count4", int'(count), 4);
        repeat (4) pop1();
        check("t2_count0", int'(count), 0);
        check("t2_valid0", int'(valid), 0);
        check("t2_key0", int'(key_out), 0);
        key_code = 8'h00;
        step(1);

        // 3: overflow, clear, full push+pop
        for (int i = 0; i < 9; i++) begin
            key_code = 8'h41 + 8'(i);
            if (i < 8) expect_evt(8'h41 + 8'(i), 1'b0);
            step(1);
        end
        key_code = 8'h00;
        step(1);
        check("t3_count_full", int'(count), 8);
        check("t3_ovf_set", int'(overflow), 1);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        check("t3_ovf_clr", int'(overflow), 0);
        key_code = 8'h50;
        expect_evt(8'h50, 1'b0);
        pop1();
        key_code = 8'h00;
        check("t3_count_pp", int'(count), 8);
        check("t3_ovf_pp", int'(overflow), 0);
        repeat (8) pop1();
        check("t3_drained", int'(count), 0);

        // 4: enabling on a held key gives nothing
        en = 1'b0;
        key_code = 8'h45;
        step(3);
        check("t4_en0", int'(count), 0);
        en = 1'b1;
        step(3);
        check("t4_en_raise", int'(count), 0);
        key_code = 8'h00;
        step(1);
        key_code = 8'h45;
        expect_evt(8'h45, 1'b0);
        step(2);
        check("t4_push", int'(count), 1);
        pop1();
        key_code = 8'h00;
        step(1);

        // 5: illegal codes and empty pops
        key_code = 8'h35; step(2);
        key_code = 8'h5B; step(2);
        key_code = 8'h61; step(2);
        check("t5_illegal", int'(count), 0);
        check("t5_valid", int'(valid), 0);
        rd_en = 1'b1;
        step(3);
        rd_en = 1'b0;
        check("t5_empty_pop", int'(count), 0);
        key_code = 8'h00;
        step(1);

        // 6: asynchronous clear mid-operation
        for (int i = 0; i < 5; i++) begin
            key_code = 8'h41 + 8'(i);
            step(1);
        end
        key_code = 8'h00;
        step(1);
        check("t6_count5", int'(count), 5);
        #2;
        clr = 1'b1;
        #1;
        check("t6_clr_valid", int'(valid), 0);
        check("t6_clr_count", int'(count), 0);
        check("t6_clr_ovf", int'(overflow), 0);
        #1;
        clr = 1'b0;
        step(1);
        key_code = 8'h31;
        expect_evt(8'h31, 1'b1);
        step(1);
        check("t6_key", int'(key_out), 8'h31);
        check("t6_count1", int'(count), 1);
        check("t6_digit", int'(key_is_digit), 1);
        pop1();
        key_code = 8'h00;
        step(2);
        check("sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
